// File: rtl/gate_probe_pkg.sv
// Shared types and constants for the gate truth-table probe: FSM states,
// the input-vector sweep table and reference truth tables for common gates.
package gate_probe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Sweep order by index: (a,b) = 00, 10, 01, 11 so truth bit i = a + 2*b.
  localparam logic VEC_A [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic VEC_B [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  function automatic int settle_cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gate_truth_probe_settle_counter.sv
// Hold-time counter for one sweep vector: counts 0..SETTLE_CYCLES-1 while
// enabled and flags the final cycle so the top level can sample the gate.
module settle_counter
  import gate_probe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int W = settle_cnt_width(SETTLE_CYCLES);
  localparam logic [W-1:0] LAST_CNT = W'(SETTLE_CYCLES - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == LAST_CNT);
  assign last      = en && w_at_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_at_last ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/gate_truth_probe.sv
// Sweeps a 2-input gate through all four input vectors and returns its truth
// table over valid/ready. Define PROBE_COMPARE_EN to add the expected/pass compare.
module gate_truth_probe
  import gate_probe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [3:0] truth
`ifdef PROBE_COMPARE_EN
  ,
  input  logic [3:0] expected,
  output logic       pass
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("gate_truth_probe: SETTLE_CYCLES must be in 1..255");
  end

  state_t     r_state;
  logic [1:0] r_idx;
  logic       r_busy;
  logic       r_a;
  logic       r_b;
  logic       r_valid;
  logic [3:0] r_truth;

  logic       w_last;
  logic       w_clr;
  logic       w_en;
  logic [1:0] w_idx_next;
  logic [3:0] w_truth_final;

  assign w_en       = (r_state == DRIVE);
  assign w_clr      = !w_en;
  assign w_idx_next = r_idx + 2'd1;

  settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (w_en),
    .last (w_last)
  );

  // Truth word as it will look once the current sample lands; also feeds the comparator.
  always_comb begin
    w_truth_final        = r_truth;
    w_truth_final[r_idx] = y;
  end

`ifdef PROBE_COMPARE_EN
  logic r_pass;
  assign pass = r_pass;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_busy  <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_valid <= 1'b0;
      r_truth <= 4'b0000;
`ifdef PROBE_COMPARE_EN
      r_pass  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= DRIVE;
            r_idx   <= 2'd0;
            r_busy  <= 1'b1;
            r_a     <= VEC_A[0];
            r_b     <= VEC_B[0];
            r_truth <= 4'b0000;
`ifdef PROBE_COMPARE_EN
            r_pass  <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          if (w_last) begin
            r_truth <= w_truth_final;
            if (r_idx == 2'd3) begin
              r_state <= RESULT;
              r_busy  <= 1'b0;
              r_a     <= 1'b0;
              r_b     <= 1'b0;
              r_valid <= 1'b1;
`ifdef PROBE_COMPARE_EN
              r_pass  <= (w_truth_final == expected);
`endif
            end else begin
              r_idx <= w_idx_next;
              r_a   <= VEC_A[w_idx_next];
              r_b   <= VEC_B[w_idx_next];
            end
          end
        end
        RESULT: begin
          if (result_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign a            = r_a;
  assign b            = r_b;
  assign result_valid = r_valid;
  assign truth        = r_truth;

endmodule
